// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matrix-multiply engine.
// Holds the control FSM state type, counter sizing and the saturating adder
// used by each PE when SYSTOLIC_SAT_EN is defined.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_e;

    localparam int DEF_DIM = 10;

    // Counter width able to hold the longest drain count (M+K-1 <= 2*DIM-1).
    function automatic int cnt_w(input int dim);
        return $clog2(2 * dim + 1);
    endfunction

    localparam int CNT_W = cnt_w(DEF_DIM);

    // Unsigned add clamped to 2**w-1 (w <= 63); callers cast the result to w bits.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int          w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/systolic_mm_engine_if.sv
// Control, operand and result bundle of the systolic matrix-multiply engine.
// master = operand source / result sink, slave = the engine itself.
interface systolic_mm_engine_if #(
    parameter int WIDTH = 8,
    parameter int DIM   = 10,
    parameter int ACC_W = 2 * WIDTH + 4
);
    localparam int DW = $clog2(DIM + 1);

    logic                     start;
    logic [DW-1:0]            cfg_m;
    logic [DW-1:0]            cfg_n;
    logic [DW-1:0]            cfg_k;
    logic                     accumulate;
    logic                     in_valid;
    logic                     in_ready;
    logic [DIM*WIDTH-1:0]     a_col;
    logic [DIM*WIDTH-1:0]     b_row;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [DIM*DIM*ACC_W-1:0] result;
    logic                     result_valid;

    modport master (
        output start, cfg_m, cfg_n, cfg_k, accumulate, in_valid, a_col, b_row,
        input  in_ready, busy, done, err, result, result_valid
    );

    modport slave (
        input  start, cfg_m, cfg_n, cfg_k, accumulate, in_valid, a_col, b_row,
        output in_ready, busy, done, err, result, result_valid
    );

endinterface

// File: rtl/systolic_pe.sv
// One output-stationary processing element: forwards A right and B down
// through registers and accumulates a*b locally.
// SYSTOLIC_SAT_EN defined: accumulator saturates at 2**ACC_W-1; otherwise it wraps.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 2 * WIDTH + 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [ACC_W-1:0] acc
);

    logic [2*WIDTH-1:0] prod;
    logic [ACC_W-1:0]   sum;

    assign prod = (2 * WIDTH)'(a_in) * (2 * WIDTH)'(b_in);

`ifdef SYSTOLIC_SAT_EN
    assign sum = ACC_W'(sat_add(64'(acc), 64'(prod), ACC_W));
`else
    assign sum = acc + ACC_W'(prod);
`endif

    // Pass operands to neighbours and fold the product into the accumulator.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= clr ? '0 : sum;
        end
    end

endmodule

// File: rtl/systolic_mm_engine.sv
// Self-sequencing DIMxDIM output-stationary systolic matrix multiplier,
// C[MxK] = A[MxN] * B[NxK] with run-time M,N,K <= DIM.
// One k-slice of A (column) and B (row) per accepted beat; skew is generated here.
// Optional feature macro: SYSTOLIC_SAT_EN (saturating accumulators inside systolic_pe).
module systolic_mm_engine
    import systolic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIM   = 10,
    parameter int ACC_W = 2 * WIDTH + 4
) (
    input logic                 clock,
    input logic                 reset,
    systolic_mm_engine_if.slave bus
);

    localparam int            DW    = $clog2(DIM + 1);
    localparam int            CW    = cnt_w(DIM);
    localparam logic [DW-1:0] DIM_V = DW'(DIM);

    state_e        state;
    logic [DW-1:0] m_q;
    logic [DW-1:0] n_q;
    logic [DW-1:0] k_q;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] drain_cnt;
    logic          busy_q;
    logic          ready_q;
    logic          done_q;
    logic          err_q;
    logic          rvalid_q;

    logic          cfg_ok;
    logic          start_ok;
    logic          beat;
    logic          clr;
    logic [CW-1:0] drain_last;

    assign cfg_ok = (bus.cfg_m != '0) && (bus.cfg_m <= DIM_V) &&
                    (bus.cfg_n != '0) && (bus.cfg_n <= DIM_V) &&
                    (bus.cfg_k != '0) && (bus.cfg_k <= DIM_V);
    assign start_ok   = (state == IDLE) && bus.start && cfg_ok;
    assign beat       = bus.in_valid && ready_q;
    // Accumulators clear on the launching edge; skew and pass registers are
    // all zero by then, so nothing from a previous run can land afterwards.
    assign clr        = start_ok && !bus.accumulate;
    // Last diagonal reaches PE(M-1,K-1) M+K-2 cycles after the final beat.
    assign drain_last = CW'(m_q) + CW'(k_q) - CW'(2);

    assign bus.in_ready     = ready_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.result_valid = rvalid_q;

    // Run control: launch, count beats, count drain cycles, signal completion.
    // NOTE: non-blocking assignments so every register samples pre-edge values
    // regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            m_q       <= '0;
            n_q       <= '0;
            k_q       <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (cfg_ok) begin
                            state    <= FEED;
                            m_q      <= bus.cfg_m;
                            n_q      <= bus.cfg_n;
                            k_q      <= bus.cfg_k;
                            beat_cnt <= '0;
                            busy_q   <= 1'b1;
                            ready_q  <= 1'b1;
                            rvalid_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (beat) begin
                        if (beat_cnt == CW'(n_q) - CW'(1)) begin
                            state     <= DRAIN;
                            ready_q   <= 1'b0;
                            drain_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == drain_last) begin
                        state    <= DONE;
                        done_q   <= 1'b1;
                        rvalid_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // a_h[i][j] feeds PE(i,j) from the left; b_v[i][j] feeds PE(i,j) from above.
    logic [WIDTH-1:0] a_h [DIM][DIM+1];
    logic [WIDTH-1:0] b_v [DIM+1][DIM];
    logic [ACC_W-1:0] acc_q [DIM][DIM];

    for (genvar i = 0; i < DIM; i++) begin : g_skew
        logic [WIDTH-1:0] a_lane;
        logic [WIDTH-1:0] b_lane;

        // Bubbles, idle cycles and lanes outside MxK inject zeros.
        assign a_lane = (beat && (DW'(i) < m_q)) ? bus.a_col[i*WIDTH +: WIDTH] : '0;
        assign b_lane = (beat && (DW'(i) < k_q)) ? bus.b_row[i*WIDTH +: WIDTH] : '0;

        if (i == 0) begin : g_direct
            assign a_h[0][0] = a_lane;
            assign b_v[0][0] = b_lane;
        end else begin : g_delay
            logic [WIDTH-1:0] a_sr [i];
            logic [WIDTH-1:0] b_sr [i];

            // Delay row i of A and column i of B by i cycles to form the wavefront.
            // NOTE: these shift stages are reset explicitly so a run never starts
            // with stale operands in flight.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    for (int d = 0; d < i; d++) begin
                        a_sr[d] <= '0;
                        b_sr[d] <= '0;
                    end
                end else begin
                    a_sr[0] <= a_lane;
                    b_sr[0] <= b_lane;
                    for (int d = 1; d < i; d++) begin
                        a_sr[d] <= a_sr[d-1];
                        b_sr[d] <= b_sr[d-1];
                    end
                end
            end

            assign a_h[i][0] = a_sr[i-1];
            assign b_v[0][i] = b_sr[i-1];
        end
    end

    for (genvar i = 0; i < DIM; i++) begin : g_row
        for (genvar j = 0; j < DIM; j++) begin : g_col
            systolic_pe #(
                .WIDTH(WIDTH),
                .ACC_W(ACC_W)
            ) u_pe (
                .clock(clock),
                .reset(reset),
                .clr  (clr),
                .a_in (a_h[i][j]),
                .b_in (b_v[i][j]),
                .a_out(a_h[i][j+1]),
                .b_out(b_v[i+1][j]),
                .acc  (acc_q[i][j])
            );

            assign bus.result[(i*DIM+j)*ACC_W +: ACC_W] = acc_q[i][j];
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Scoreboard bench for systolic_mm_engine: the stimulus process pushes the
// expected result and completion cycle of each run; monitors pop and compare
// whenever done is presented.
module tb_systolic_mm_engine;

    localparam int WIDTH  = 8;
    localparam int DIM    = 10;
    localparam int ACC_W  = 2 * WIDTH + 4;
    localparam int DW     = $clog2(DIM + 1);
    localparam int RW     = DIM * DIM * ACC_W;
    localparam int DIM2   = 2;
    localparam int ACC_W2 = 16;
    localparam int DW2    = $clog2(DIM2 + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_mm_engine_if #(.WIDTH(WIDTH), .DIM(DIM),  .ACC_W(ACC_W))  bus  ();
    systolic_mm_engine_if #(.WIDTH(WIDTH), .DIM(DIM2), .ACC_W(ACC_W2)) bus2 ();

    systolic_mm_engine #(.WIDTH(WIDTH), .DIM(DIM), .ACC_W(ACC_W)) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus.slave)
    );

    systolic_mm_engine #(.WIDTH(WIDTH), .DIM(DIM2), .ACC_W(ACC_W2)) dut2 (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus2.slave)
    );

    // Operand and hand-computed product tables.
    int a3 [3][3] = '{'{2, 3, 9}, '{1, 1, 5}, '{5, 1, 0}};
    int b3 [3][4] = '{'{2, 6, 1, 4}, '{0, 2, 2, 5}, '{9, 1, 8, 2}};
    int c3 [3][4] = '{'{85, 27, 80, 41}, '{47, 13, 43, 19}, '{10, 32, 7, 25}};

    typedef struct {
        logic [RW-1:0] res;
        int            cyc;
        int            id;
    } exp_t;

    typedef struct {
        logic [63:0] val;
        int          cyc;
    } exp2_t;

    exp_t  exp_q  [$];
    exp2_t exp2_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    function automatic logic [RW-1:0] pack_c(input int scale);
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++)
                r[(i*DIM+j)*ACC_W +: ACC_W] = ACC_W'(c3[i][j] * scale);
        return r;
    endfunction

    // Lanes outside the active shape and bubble beats carry nonzero junk.
    task automatic drive_beat(input bit v, input int t, input int m, input int k);
        bus.in_valid = v;
        for (int i = 0; i < DIM; i++) begin
            if (v && i < m) bus.a_col[i*WIDTH +: WIDTH] = WIDTH'(a3[i][t]);
            else            bus.a_col[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(1, 255));
            if (v && i < k) bus.b_row[i*WIDTH +: WIDTH] = WIDTH'(b3[t][i]);
            else            bus.b_row[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(1, 255));
        end
    endtask

    task automatic run_mm(input int id, input int m, input int n, input int k,
                          input bit acc, input bit alt, input logic [RW-1:0] want);
        int   idx;
        int   guard;
        bit   v;
        bit   took;
        exp_t e;
        @(posedge clk); #1;
        bus.start      = 1'b1;
        bus.cfg_m      = DW'(m);
        bus.cfg_n      = DW'(n);
        bus.cfg_k      = DW'(k);
        bus.accumulate = acc;
        e.res = want;
        e.cyc = cyc + m + n + k + (alt ? n : 0);
        e.id  = id;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        idx   = 0;
        guard = 0;
        while (idx < n && guard < 40) begin
            v = alt ? (guard % 2 == 1) : 1'b1;
            drive_beat(v, idx, m, k);
            @(negedge clk);
            took = v && bus.in_ready;
            @(posedge clk); #1;
            if (took) idx++;
            guard++;
        end
        bus.in_valid = 1'b0;
        check($sformatf("run%0d_beats_taken", id), 64'(idx), 64'(n));
        guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            @(posedge clk);
            guard++;
        end
        check($sformatf("run%0d_done_seen", id), 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    // Main-array monitor: pops one expectation per done pulse.
    always @(negedge clk) begin : mon
        exp_t e;
        int   bad;
        if (rst_n && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(bus.done), 64'(0));
            end else begin
                e   = exp_q.pop_front();
                bad = -1;
                for (int sl = 0; sl < DIM * DIM; sl++)
                    if (bad < 0 && bus.result[sl*ACC_W +: ACC_W] !== e.res[sl*ACC_W +: ACC_W])
                        bad = sl;
                if (bad < 0) bad = 0;
                check($sformatf("run%0d_C[%0d][%0d]", e.id, bad / DIM, bad % DIM),
                      64'(bus.result[bad*ACC_W +: ACC_W]), 64'(e.res[bad*ACC_W +: ACC_W]));
                check($sformatf("run%0d_done_cycle", e.id), 64'(cyc), 64'(e.cyc));
                check($sformatf("run%0d_result_valid", e.id), 64'(bus.result_valid), 64'(1));
            end
        end
    end

    // Narrow-accumulator monitor for the saturate/wrap case.
    always @(negedge clk) begin : mon2
        exp2_t e2;
        if (rst_n && bus2.done === 1'b1) begin
            if (exp2_q.size() == 0) begin
                check("unexpected_done2", 64'(bus2.done), 64'(0));
            end else begin
                e2 = exp2_q.pop_front();
                check("ovf_C00", 64'(bus2.result[ACC_W2-1:0]), e2.val);
                check("ovf_done_cycle", 64'(cyc), 64'(e2.cyc));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp2_t e2;
        int    guard;
        bus.start = 1'b0;  bus.cfg_m = '0; bus.cfg_n = '0; bus.cfg_k = '0;
        bus.accumulate = 1'b0; bus.in_valid = 1'b0; bus.a_col = '0; bus.b_row = '0;
        bus2.start = 1'b0; bus2.cfg_m = '0; bus2.cfg_n = '0; bus2.cfg_k = '0;
        bus2.accumulate = 1'b0; bus2.in_valid = 1'b0; bus2.a_col = '0; bus2.b_row = '0;
        rst_n = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",         64'(bus.busy),         64'(0));
        check("rst_in_ready",     64'(bus.in_ready),     64'(0));
        check("rst_done",         64'(bus.done),         64'(0));
        check("rst_err",          64'(bus.err),          64'(0));
        check("rst_result_valid", 64'(bus.result_valid), 64'(0));
        check("rst_result_any",   64'(|bus.result),      64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // 1: no bubbles, 2: alternating bubbles, 3: accumulate on top of C
        run_mm(1, 3, 3, 4, 1'b0, 1'b0, pack_c(1));
        run_mm(2, 3, 3, 4, 1'b0, 1'b1, pack_c(1));
        run_mm(3, 3, 3, 4, 1'b1, 1'b0, pack_c(2));

        // 4: illegal configurations, with junk beats offered while idle
        @(posedge clk); #1;
        drive_beat(1'b0, 0, 0, 0);
        bus.in_valid = 1'b1;
        bus.start = 1'b1; bus.cfg_m = '0; bus.cfg_n = DW'(3); bus.cfg_k = DW'(4);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("bad_m_err",      64'(bus.err),      64'(1));
        check("bad_m_busy",     64'(bus.busy),     64'(0));
        check("bad_m_in_ready", 64'(bus.in_ready), 64'(0));
        @(posedge clk); #1;
        check("bad_m_err_pulse", 64'(bus.err), 64'(0));
        bus.start = 1'b1; bus.cfg_m = DW'(3); bus.cfg_k = DW'(DIM + 1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("bad_k_err",      64'(bus.err),      64'(1));
        check("bad_k_busy",     64'(bus.busy),     64'(0));
        check("bad_k_in_ready", 64'(bus.in_ready), 64'(0));
        @(posedge clk); #1;
        check("bad_k_err_pulse", 64'(bus.err), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("held_C00",         64'(bus.result[0 +: ACC_W]),            64'(170));
        check("held_C23",         64'(bus.result[(2*DIM+3)*ACC_W +: ACC_W]), 64'(50));
        check("held_C04",         64'(bus.result[4*ACC_W +: ACC_W]),      64'(0));
        check("held_result_valid", 64'(bus.result_valid),                 64'(1));

        // 6: reset during FEED, then a clean rerun of test 1
        @(posedge clk); #1;
        bus.start = 1'b1; bus.cfg_m = DW'(3); bus.cfg_n = DW'(3); bus.cfg_k = DW'(4);
        bus.accumulate = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        drive_beat(1'b1, 0, 3, 4);
        @(posedge clk); #1;
        drive_beat(1'b1, 1, 3, 4);
        @(posedge clk); #1;
        check("pre_rst_partial", 64'(|bus.result), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",         64'(bus.busy),         64'(0));
        check("mid_rst_in_ready",     64'(bus.in_ready),     64'(0));
        check("mid_rst_result_valid", 64'(bus.result_valid), 64'(0));
        check("mid_rst_result_any",   64'(|bus.result),      64'(0));
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_mm(4, 3, 3, 4, 1'b0, 1'b0, pack_c(1));

        // 5: 255*255 twice into a 16-bit accumulator
        @(posedge clk); #1;
        bus2.start = 1'b1; bus2.cfg_m = DW2'(1); bus2.cfg_n = DW2'(2); bus2.cfg_k = DW2'(1);
`ifdef SYSTOLIC_SAT_EN
        e2.val = 64'd65535;
`else
        e2.val = 64'd64514;
`endif
        e2.cyc = cyc + 4;
        exp2_q.push_back(e2);
        @(posedge clk); #1;
        bus2.start    = 1'b0;
        bus2.in_valid = 1'b1;
        bus2.a_col    = {DIM2{8'd255}};
        bus2.b_row    = {DIM2{8'd255}};
        repeat (2) @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        guard = 0;
        while (exp2_q.size() != 0 && guard < 40) begin
            @(posedge clk);
            guard++;
        end
        check("ovf_done_seen", 64'(exp2_q.size()), 64'(0));

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
